// File: rtl/demux_dispatch_1to4.sv
// rtl/demux_dispatch_1to4.sv - registered 1:4 dispatcher with per-lane one-entry holding registers
module demux_dispatch_1to4 #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              mode,
    input  logic [1:0]        select,
    output logic [DATA_W-1:0] out0,
    output logic [DATA_W-1:0] out1,
    output logic [DATA_W-1:0] out2,
    output logic [DATA_W-1:0] out3,
    output logic [3:0]        out_valid,
    input  logic [3:0]        out_ready,
    output logic [1:0]        rr_ptr
);

    logic [DATA_W-1:0] lane_data [4];
    logic [3:0]        lane_valid;
    logic [1:0]        target;
    logic              accept;
    logic [3:0]        load;
    logic [3:0]        pop;

    assign target = mode ? select : rr_ptr;

    // Only the targeted lane gates upstream; a draining lane can be refilled in the same cycle.
    assign in_ready = !lane_valid[target] | out_ready[target];
    assign accept   = in_valid & in_ready;
    assign pop      = lane_valid & out_ready;

    always_comb begin
        load         = 4'b0000;
        load[target] = accept;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lane_valid <= 4'b0000;
            rr_ptr     <= 2'd0;
            for (int i = 0; i < 4; i++) begin
                lane_data[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (load[i]) begin
                    lane_data[i]  <= in_data;
                    lane_valid[i] <= 1'b1;
                end else if (pop[i]) begin
                    lane_valid[i] <= 1'b0;
                end
            end
            if (accept && !mode) begin
                rr_ptr <= rr_ptr + 2'd1;
            end
        end
    end

    assign out0      = lane_data[0];
    assign out1      = lane_data[1];
    assign out2      = lane_data[2];
    assign out3      = lane_data[3];
    assign out_valid = lane_valid;

endmodule

// File: tb/tb_demux_dispatch_1to4.sv
// tb/tb_demux_dispatch_1to4.sv - directed vector table plus randomized run against a lane model
module tb_demux_dispatch_1to4;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       mode;
    logic [1:0] select;
    logic [7:0] out0, out1, out2, out3;
    logic [3:0] out_valid;
    logic [3:0] out_ready;
    logic [1:0] rr_ptr;

    demux_dispatch_1to4 #(.DATA_W(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .mode      (mode),
        .select    (select),
        .out0      (out0),
        .out1      (out1),
        .out2      (out2),
        .out3      (out3),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .rr_ptr    (rr_ptr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic       iv;
        logic [7:0] d;
        logic       md;
        logic [1:0] sel;
        logic [3:0] ordy;
        logic       chk_ir;
        logic       exp_ir;
        logic [3:0] exp_valid;
        logic [1:0] exp_ptr;
        int         lane;
        logic [7:0] exp_data;
    } vec_t;

    vec_t vq[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    logic [7:0] m_data [4];
    bit         m_valid [4];
    int         m_ptr;
    bit         m_known = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    function automatic logic [7:0] lane_out(input int i);
        case (i)
            0:       return out0;
            1:       return out1;
            2:       return out2;
            default: return out3;
        endcase
    endfunction

    function automatic logic [3:0] model_valid_vec();
        logic [3:0] v;
        for (int i = 0; i < 4; i++) v[i] = m_valid[i];
        return v;
    endfunction

    task automatic add(input logic rst, input logic iv, input logic [7:0] d, input logic md,
                       input logic [1:0] sel, input logic [3:0] ordy, input logic chk_ir,
                       input logic exp_ir, input logic [3:0] ev, input logic [1:0] ep,
                       input int lane, input logic [7:0] ed);
        vec_t v;
        v = '{rst, iv, d, md, sel, ordy, chk_ir, exp_ir, ev, ep, lane, ed};
        vq.push_back(v);
    endtask

    // Drives one cycle, checks in_ready before the edge and all state after it against the model.
    task automatic apply(input logic rst, input logic iv, input logic [7:0] d, input logic md,
                         input logic [1:0] sel, input logic [3:0] ordy, output logic ir_seen);
        int  t;
        bit  rdy;
        rst_n     = ~rst;
        in_valid  = iv;
        in_data   = d;
        mode      = md;
        select    = sel;
        out_ready = ordy;
        #1;
        ir_seen = in_ready;
        t   = md ? int'(sel) : m_ptr;
        rdy = m_known && (!m_valid[t] || ordy[t]);
        if (m_known) chk("in_ready", {31'd0, in_ready}, {31'd0, rdy});
        @(posedge clk);
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                m_data[i]  = 8'h00;
                m_valid[i] = 0;
            end
            m_ptr   = 0;
            m_known = 1;
        end else if (m_known) begin
            for (int i = 0; i < 4; i++)
                if (m_valid[i] && ordy[i]) m_valid[i] = 0;
            if (iv && rdy) begin
                m_data[t]  = d;
                m_valid[t] = 1;
                if (!md) m_ptr = (m_ptr + 1) % 4;
            end
        end
        #1;
        if (m_known) begin
            chk("out_valid", {28'd0, out_valid}, {28'd0, model_valid_vec()});
            chk("rr_ptr", {30'd0, rr_ptr}, m_ptr);
            for (int i = 0; i < 4; i++)
                chk($sformatf("out%0d", i), {24'd0, lane_out(i)}, {24'd0, m_data[i]});
        end
    endtask

    initial begin
        logic ir;
        rst_n = 1'b0; in_valid = 1'b0; in_data = 8'h00; mode = 1'b0;
        select = 2'b00; out_ready = 4'b0000;

        // rst iv data md sel ordy chk_ir exp_ir valid ptr lane data
        add(1, 0, 8'h00, 0, 2'd0, 4'b0000, 0, 0, 4'b0000, 2'd0, 0, 8'h00);
        add(0, 1, 8'hA0, 0, 2'd0, 4'b1111, 1, 1, 4'b0001, 2'd1, 0, 8'hA0);
        add(0, 1, 8'hA1, 0, 2'd0, 4'b1111, 1, 1, 4'b0010, 2'd2, 1, 8'hA1);
        add(0, 1, 8'hA2, 0, 2'd0, 4'b1111, 1, 1, 4'b0100, 2'd3, 2, 8'hA2);
        add(0, 1, 8'hA3, 0, 2'd0, 4'b1111, 1, 1, 4'b1000, 2'd0, 3, 8'hA3);
        add(0, 1, 8'hA4, 0, 2'd0, 4'b1111, 1, 1, 4'b0001, 2'd1, 0, 8'hA4);
        add(0, 0, 8'h00, 0, 2'd0, 4'b1111, 1, 1, 4'b0000, 2'd1, 0, 8'hA4);
        add(1, 0, 8'h00, 0, 2'd0, 4'b0000, 1, 1, 4'b0000, 2'd0, 0, 8'h00);
        add(0, 1, 8'h11, 0, 2'd0, 4'b0000, 1, 1, 4'b0001, 2'd1, 0, 8'h11);
        add(0, 1, 8'h22, 0, 2'd0, 4'b0000, 1, 1, 4'b0011, 2'd2, 1, 8'h22);
        add(0, 1, 8'h33, 0, 2'd0, 4'b0000, 1, 1, 4'b0111, 2'd3, 2, 8'h33);
        add(0, 1, 8'h44, 0, 2'd0, 4'b0000, 1, 1, 4'b1111, 2'd0, 3, 8'h44);
        add(0, 1, 8'h55, 0, 2'd0, 4'b0000, 1, 0, 4'b1111, 2'd0, 0, 8'h11);
        add(0, 1, 8'h55, 0, 2'd0, 4'b0001, 1, 1, 4'b1111, 2'd1, 0, 8'h55);
        add(0, 0, 8'h00, 0, 2'd0, 4'b1111, 1, 1, 4'b0000, 2'd1, 2, 8'h33);
        add(0, 1, 8'h5A, 1, 2'd2, 4'b0000, 1, 1, 4'b0100, 2'd1, 2, 8'h5A);
        add(0, 1, 8'h6B, 1, 2'd2, 4'b0000, 1, 0, 4'b0100, 2'd1, 2, 8'h5A);
        add(0, 1, 8'h6B, 1, 2'd1, 4'b0000, 1, 1, 4'b0110, 2'd1, 1, 8'h6B);
        add(0, 1, 8'h77, 1, 2'd1, 4'b0010, 1, 1, 4'b0110, 2'd1, 1, 8'h77);
        add(0, 1, 8'h88, 1, 2'd1, 4'b0010, 1, 1, 4'b0110, 2'd1, 1, 8'h88);
        add(0, 1, 8'hC1, 0, 2'd0, 4'b0110, 1, 1, 4'b0010, 2'd2, 1, 8'hC1);
        add(0, 1, 8'hD0, 1, 2'd0, 4'b0000, 1, 1, 4'b0011, 2'd2, 0, 8'hD0);
        add(0, 1, 8'hE3, 1, 2'd3, 4'b0000, 1, 1, 4'b1011, 2'd2, 3, 8'hE3);
        add(1, 1, 8'hF0, 1, 2'd3, 4'b1111, 1, 1, 4'b0000, 2'd0, 3, 8'h00);
        add(0, 0, 8'h00, 0, 2'd0, 4'b0000, 1, 1, 4'b0000, 2'd0, 1, 8'h00);

        @(posedge clk);
        #1;
        for (int k = 0; k < vq.size(); k++) begin
            apply(vq[k].rst, vq[k].iv, vq[k].d, vq[k].md, vq[k].sel, vq[k].ordy, ir);
            if (vq[k].chk_ir)
                chk($sformatf("vec%0d_in_ready", k), {31'd0, ir}, {31'd0, vq[k].exp_ir});
            chk($sformatf("vec%0d_out_valid", k), {28'd0, out_valid}, {28'd0, vq[k].exp_valid});
            chk($sformatf("vec%0d_rr_ptr", k), {30'd0, rr_ptr}, {30'd0, vq[k].exp_ptr});
            chk($sformatf("vec%0d_out%0d", k, vq[k].lane), {24'd0, lane_out(vq[k].lane)},
                {24'd0, vq[k].exp_data});
        end

        for (int k = 0; k < 3000; k++) begin
            apply($urandom_range(0, 63) == 0, $urandom_range(0, 3) != 0, 8'($urandom),
                  $urandom_range(0, 2) == 0, 2'($urandom), 4'($urandom), ir);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/demux_dispatch_1to4.md
Name: demux_dispatch_1to4

Overview:
- Registered 1:4 dispatcher that sits directly upstream of the combinational 1:4 demux datapath. It drives that stage's input and lane selection with flow control.
- Accepts a single valid/ready input stream and routes each word into one of four output lanes. Each lane has a one-entry holding register.
- Lane choice is either round-robin or an explicit 2-bit select. Upstream is stalled only when the targeted lane is occupied and not draining.

Parameters:
- DATA_W, 8, width of the data word carried on input and every output lane.

Ports:
- clk  input  1  single clock; all state updates on rising edge
- rst_n  input  1  synchronous, active-low reset; sampled on rising edge of clk
- in_valid  input  1  upstream word present
- in_ready  output  1  dispatcher can accept the word this cycle (combinational)
- in_data  input  DATA_W  upstream word
- mode  input  1  0 = round-robin lane choice, 1 = explicit lane choice via select
- select  input  2  target lane when mode=1 (00→lane0 … 11→lane3)
- out0, out1, out2, out3  output  DATA_W each  lane holding-register contents
- out_valid  output  4  bit i = lane i holds an undelivered word
- out_ready  input  4  bit i = downstream of lane i takes the word this cycle
- rr_ptr  output  2  current round-robin pointer (next lane in mode 0)

Behaviour:
- Target lane: T = select when mode=1, else T = rr_ptr. Evaluated combinationally each cycle.
- in_ready = !out_valid[T] | out_ready[T].
  - Independent of in_valid.
  - Must not depend on any other lane's state.
- Accept: in_valid & in_ready at a rising edge.
  - On accept, outT ← in_data and out_valid[T] ← 1 at that edge.
  - Latency is 1 cycle: the word is visible on outT in the cycle after acceptance.
- Pop: out_valid[i] & out_ready[i] at an edge.
  - Clears out_valid[i] unless lane i is loaded at the same edge.
  - outi data is not cleared on pop; it holds its last value.
- Simultaneous pop and load on the same lane: out_valid[i] stays 1 and outi takes the new word. There is no bubble, giving full throughput of 1 word/cycle per lane.
- Non-target lanes never change data on an accept. Their valid changes only by their own pop.
- out_ready[i] while out_valid[i]=0 is ignored.
- Round-robin pointer:
  - mode=0: rr_ptr increments by 1 on each accept. It wraps 3→0 (2-bit modulo) and holds when there is no accept.
  - mode=1: rr_ptr holds its value regardless of accepts.
- Mode/select changes take effect in the same cycle; there is no internal state to flush. On return to mode=0, round-robin resumes from the held rr_ptr.
- Stall (in_valid=1, in_ready=0):
  - No state change except pops on other lanes.
  - rr_ptr does not advance; the same lane stays targeted until it frees. There is no skipping to a free lane.
- Reset (rst_n=0 at an edge):
  - out_valid=4'b0000, out0..out3=0, rr_ptr=0. This applies mid-operation too: pending words are discarded, not delivered.
  - in_ready evaluates to 1 in the first cycle after reset.
  - Reset has priority over simultaneous accept/pop.
- Everything is in one clock domain. No X on any output after the first reset edge.

Test Plan:
- Reset then round-robin:
  - Stimulus: after reset, mode=0, out_ready=4'b1111, in_valid=1 with in_data 8'hA0,A1,A2,A3,A4 on consecutive cycles.
  - Required: out0=A0, out1=A1, out2=A2, out3=A3, then out0=A4. Each word appears one cycle after acceptance; rr_ptr sequence is 0,1,2,3,0,1; in_ready stays 1 throughout.
- Backpressure stall:
  - Stimulus: mode=0, out_ready=4'b0000; send 8'h11,22,33,44, then 8'h55.
  - Required: all four lanes load and out_valid=4'b1111. in_ready=0 with rr_ptr=0 while 8'h55 waits. Raising out_ready[0] for one cycle accepts 8'h55 into out0 in that same cycle; out_valid[0] stays 1.
- Explicit select:
  - Stimulus: mode=1, select=2'b10, out_ready=4'b0000; send 8'h5A, then 8'h6B.
  - Required: out2=5A, out_valid=4'b0100. 8'h6B stalls because lane2 is full, while rr_ptr is unchanged. Changing select to 2'b01 accepts 6B into out1 the next cycle.
- Simultaneous pop and load:
  - Stimulus: lane1 holds 8'h77, mode=1, select=1, out_ready[1]=1, in_valid=1 with in_data=8'h88.
  - Required: out1=88 and out_valid[1] stays 1 continuously, with no 0-cycle gap.
- Reset mid-operation:
  - Stimulus: out_valid=4'b1011 with rr_ptr=2, then rst_n=0 for one edge.
  - Required: out_valid=0, out0..out3=0, rr_ptr=0, and in_ready=1 on the next cycle. No lane reports valid data after reset.
